cmd_fetcher: RTL and testbench
==============================

# cmd_fetcher

Command-sequencer front end that drives the command memory's `NEXT_CMD` input and consumes its `data` output. Each fetch is one request pulse, then a fixed memory-latency wait, then a capture of the word. The captured word is split into opcode and argument fields and presented to the downstream avionics controller on a valid/ready handshake. Fetching stops on a designated halt opcode. The block runs in the 26 MHz system domain.

## Interface
Parameters:
- `DATA_W`, 16, width of the command memory word.
- `OP_W`, 4, opcode field width (top `OP_W` bits of the word).
- `MEM_LAT`, 2, cycles from the `NEXT_CMD` cycle to the cycle in which `data` is valid. Legal range 1..15.
- `HALT_OP`, 4'hF, opcode value that ends the program.

Ports:
- `CLK` in 1: system clock, 26 MHz. Single clock domain.
- `RST` in 1: asynchronous, active-low reset.
- `START` in 1: level, sampled each cycle; begins or resumes fetching.
- `NEXT_CMD` out 1: registered, one-cycle-high request to the command memory.
- `data` in `DATA_W`: command word from the command memory.
- `cmd_valid` out 1: captured command available.
- `cmd_op` out `OP_W`: `data[DATA_W-1 -: OP_W]` as captured.
- `cmd_arg` out `DATA_W-OP_W`: `data[DATA_W-OP_W-1:0]` as captured.
- `cmd_ready` in 1: downstream accepts the command.
- `busy` out 1: high in REQ, WAIT and PRESENT.
- `halted` out 1: high in HALTED.
- `fetch_count` out 8: count of `NEXT_CMD` pulses issued; wraps modulo 256.

## Operation
State machine states: IDLE, REQ, WAIT, PRESENT, HALTED.
- IDLE: all outputs low. If `START`=1, go to REQ.
- REQ (one cycle):
  - `NEXT_CMD`=1.
  - `fetch_count` increments.
  - Wait counter loads `MEM_LAT`-1.
  - Go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter reads 0, `data` is registered into `cmd_op`/`cmd_arg`.
  - On that same edge, the next state is chosen:
    - captured opcode = `HALT_OP` → HALTED.
    - otherwise → PRESENT.
- PRESENT:
  - `cmd_valid`=1.
  - `cmd_op`/`cmd_arg` are held stable.
  - On an edge with `cmd_ready`=1, go to REQ. `cmd_valid` drops in the same cycle that `NEXT_CMD` rises.
- HALTED:
  - `halted`=1 and `cmd_valid`=0.
  - `cmd_op`/`cmd_arg` keep the halt word for debug.
  - `START`=1 → REQ. The memory advances past the halt word; the block does not rewind.
- `START` is ignored in REQ, WAIT and PRESENT.
- `cmd_ready` is ignored outside PRESENT.
- `fetch_count` wraps 255 → 0 with no flag.
- It is cleared only by reset; a restart from HALTED does not clear it.

## Timing
- Reset (async assert, sync release) forces IDLE and sets every output to 0: `NEXT_CMD`, `cmd_valid`, `cmd_op`, `cmd_arg`, `busy`, `halted`, `fetch_count`.
- Reset mid-fetch or mid-PRESENT discards the captured word with no further `NEXT_CMD`. The first `START` after release fetches afresh.
- Cycle numbering, with `NEXT_CMD` high in cycle c:
  - `data` is sampled at the end of cycle c+`MEM_LAT`.
  - `cmd_valid` is first high in cycle c+`MEM_LAT`+1.
- `START` high in cycle s → `NEXT_CMD` high in cycle s+1.
- Handshake completing at the end of cycle h → next `NEXT_CMD` high in cycle h+1.
- Peak throughput is one command per `MEM_LAT`+2 cycles, which is 4 cycles at the default.
- `NEXT_CMD` is never high on two consecutive cycles. It is never high while `cmd_valid`=1.
- `cmd_ready` held high continuously is legal and produces back-to-back fetches at peak rate.
- `cmd_valid`, once high, stays high until the handshake. Its payload does not change while it is high.

## Test plan
1. Single fetch, `MEM_LAT`=2:
   - Stimulus: reset, then `START` pulse in cycle 0, memory word 16'h3A5C.
   - Response: `NEXT_CMD` high in cycle 1 only; `cmd_valid` from cycle 4; `cmd_op`=4'h3, `cmd_arg`=12'hA5C; `fetch_count`=1.
2. Backpressure:
   - Stimulus: hold `cmd_ready`=0 for 10 cycles after valid, then 1.
   - Response: `cmd_valid` and payload constant throughout; no `NEXT_CMD` during the stall; `NEXT_CMD` in the cycle after acceptance.
3. Streaming:
   - Stimulus: `cmd_ready` tied to 1; memory sequence 0x1001, 0x2002, 0x3003, 0xF000.
   - Response: three commands accepted 4 cycles apart, then `halted`=1, `busy`=0, `cmd_op`=4'hF, `fetch_count`=4.
4. Restart from halt:
   - Stimulus: `START` in HALTED, next word 0x4004.
   - Response: `halted` drops with `NEXT_CMD`; command 0x4/0x004 presented; `fetch_count`=5.
5. Reset mid-WAIT:
   - Stimulus: assert `RST` low in the WAIT cycle.
   - Response: all outputs 0 immediately (async); after release, no `NEXT_CMD` until `START`.
6. Counter wrap and `MEM_LAT`=1 build:
   - Stimulus: 257 fetches of non-halt words.
   - Response: `fetch_count`=1; command period 3 cycles; `START` pulses during busy states have no effect.

Source files
------------

// File: rtl/cmd_fetcher_if.sv
// Command memory and downstream command handshake signals between the fetcher,
// the command memory and the avionics controller.
interface cmd_fetcher_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
);
    logic                   NEXT_CMD;
    logic [DATA_W-1:0]      data;
    logic                   cmd_valid;
    logic [OP_W-1:0]        cmd_op;
    logic [DATA_W-OP_W-1:0] cmd_arg;
    logic                   cmd_ready;

    modport master (
        output NEXT_CMD,
        input  data,
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  NEXT_CMD,
        output data,
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/cmd_fetcher.sv
// Command fetcher: pulses NEXT_CMD, waits out the memory latency, captures the
// word and offers it downstream as opcode/argument until accepted or halted.
//
// state   | meaning
// IDLE    | after reset, waiting for START
// REQ     | NEXT_CMD high for one cycle, latency timer loaded
// WAIT    | timer counting down; word captured when it reads 0
// PRESENT | cmd_valid high until cmd_ready
// HALTED  | halt opcode captured, waiting for START to resume
module cmd_fetcher #(
    parameter int              DATA_W  = 16,
    parameter int              OP_W    = 4,
    parameter int              MEM_LAT = 2,
    parameter logic [OP_W-1:0] HALT_OP = 4'hF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    cmd_fetcher_if.master bus,
    output logic          busy,
    output logic          halted,
    output logic [7:0]    fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PRESENT,
        S_HALTED
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;
    logic       capture;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            bus.NEXT_CMD <= 1'b0;
            fetch_count  <= '0;
            bus.cmd_op   <= '0;
            bus.cmd_arg  <= '0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            bus.NEXT_CMD <= (state_nxt == S_REQ);
            if (state == S_REQ) begin
                fetch_count <= fetch_count + 8'd1;
            end
            if (capture) begin
                bus.cmd_op  <= bus.data[DATA_W-1 -: OP_W];
                bus.cmd_arg <= bus.data[DATA_W-OP_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        capture      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) state_nxt = S_REQ;
            end
            S_REQ: begin
                wait_cnt_nxt = LAT_M1;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    capture = 1'b1;
                    // decide on the live memory word, not the register it is being loaded into
                    if (bus.data[DATA_W-1 -: OP_W] == HALT_OP) state_nxt = S_HALTED;
                    else                                      state_nxt = S_PRESENT;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_PRESENT: begin
                if (bus.cmd_ready) state_nxt = S_REQ;
            end
            S_HALTED: begin
                if (START) state_nxt = S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.cmd_valid = (state == S_PRESENT);
    assign busy          = (state == S_REQ) || (state == S_WAIT) || (state == S_PRESENT);
    assign halted        = (state == S_HALTED);

endmodule

// File: tb/tb_cmd_fetcher.sv
// Directed bench for cmd_fetcher: a MEM_LAT=2 instance with a stream memory
// model, and a MEM_LAT=1 instance for the counter wrap and peak-rate run.
module tb_cmd_fetcher;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       busy0, halted0, busy1, halted1;
    logic [7:0] fc0, fc1;

    int checks = 0;
    int fails  = 0;

    logic [15:0] mem [0:511];
    logic [8:0]  mptr = '0;

    int viol0 = 0;
    int viol1 = 0;
    logic        prev_nc0 = 1'b0, prev_v0 = 1'b0, prev_nc1 = 1'b0, prev_v1 = 1'b0;
    logic [15:0] prev_pl0 = '0, prev_pl1 = '0;

    cmd_fetcher_if #(.DATA_W(16), .OP_W(4)) bus0 ();
    cmd_fetcher_if #(.DATA_W(16), .OP_W(4)) bus1 ();

    cmd_fetcher #(.DATA_W(16), .OP_W(4), .MEM_LAT(2), .HALT_OP(4'hF)) dut0 (
        .CLK(clk), .RST(rst), .START(start0), .bus(bus0),
        .busy(busy0), .halted(halted0), .fetch_count(fc0)
    );

    cmd_fetcher #(.DATA_W(16), .OP_W(4), .MEM_LAT(1), .HALT_OP(4'hF)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .bus(bus1),
        .busy(busy1), .halted(halted1), .fetch_count(fc1)
    );

    always #5 clk = ~clk;

    // command memory: each request advances through the stream, word held until the next one
    always @(posedge clk) begin
        if (bus0.NEXT_CMD) begin
            bus0.data <= mem[mptr];
            mptr      <= mptr + 9'd1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus0.NEXT_CMD && prev_nc0) viol0++;
            if (bus0.NEXT_CMD && bus0.cmd_valid) viol0++;
            if (bus0.cmd_valid && prev_v0 && ({bus0.cmd_op, bus0.cmd_arg} != prev_pl0)) viol0++;
            if (bus1.NEXT_CMD && prev_nc1) viol1++;
            if (bus1.NEXT_CMD && bus1.cmd_valid) viol1++;
            if (bus1.cmd_valid && prev_v1 && ({bus1.cmd_op, bus1.cmd_arg} != prev_pl1)) viol1++;
        end
        prev_nc0 = bus0.NEXT_CMD;
        prev_v0  = bus0.cmd_valid;
        prev_pl0 = {bus0.cmd_op, bus0.cmd_arg};
        prev_nc1 = bus1.NEXT_CMD;
        prev_v1  = bus1.cmd_valid;
        prev_pl1 = {bus1.cmd_op, bus1.cmd_arg};
    end

    task automatic apply_reset();
        rst = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        bus0.cmd_ready = 1'b0;
        bus1.cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus0.cmd_ready = 1'b0;
        bus1.cmd_ready = 1'b0;
        bus1.data = 16'h1234;
        @(negedge clk);
        checks++;
        if ({bus0.NEXT_CMD, bus0.cmd_valid, bus0.cmd_op, bus0.cmd_arg, busy0, halted0, fc0} !== 28'd0) begin
            fails++;
            $display("FAIL reset_dut0: got nc=%b v=%b op=%h arg=%h busy=%b halt=%b fc=%0d, want all 0",
                     bus0.NEXT_CMD, bus0.cmd_valid, bus0.cmd_op, bus0.cmd_arg, busy0, halted0, fc0);
        end
        checks++;
        if ({bus1.NEXT_CMD, bus1.cmd_valid, bus1.cmd_op, bus1.cmd_arg, busy1, halted1, fc1} !== 28'd0) begin
            fails++;
            $display("FAIL reset_dut1: got nc=%b v=%b op=%h arg=%h busy=%b halt=%b fc=%0d, want all 0",
                     bus1.NEXT_CMD, bus1.cmd_valid, bus1.cmd_op, bus1.cmd_arg, busy1, halted1, fc1);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.NEXT_CMD, busy0, halted0} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_release: got nc/busy/halt=%b, want 000", {bus0.NEXT_CMD, busy0, halted0});
        end
    endtask

    task automatic test_single_fetch();
        logic [5:0] nc_tr;
        logic [5:0] v_tr;
        mem[mptr] = 16'h3A5C;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nc_tr[i] = bus0.NEXT_CMD;
            v_tr[i]  = bus0.cmd_valid;
            if (i < 5) @(negedge clk);
        end
        checks++;
        if (nc_tr !== 6'b000001) begin
            fails++;
            $display("FAIL single_next_cmd_trace: got %b, want 000001 (cycles 6..1)", nc_tr);
        end
        checks++;
        if (v_tr !== 6'b111000) begin
            fails++;
            $display("FAIL single_valid_trace: got %b, want 111000 (cycles 6..1)", v_tr);
        end
        checks++;
        if ({bus0.cmd_op, bus0.cmd_arg} !== 16'h3A5C) begin
            fails++;
            $display("FAIL single_payload: got op=%h arg=%h, want op=3 arg=a5c", bus0.cmd_op, bus0.cmd_arg);
        end
        checks++;
        if (fc0 !== 8'd1) begin
            fails++;
            $display("FAIL single_fetch_count: got %0d, want 1", fc0);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus0.NEXT_CMD, bus0.cmd_valid, bus0.cmd_op, bus0.cmd_arg} !== {2'b01, 16'h3A5C}) begin
                fails++;
                $display("FAIL stall_cycle_%0d: got nc=%b v=%b payload=%h, want nc=0 v=1 payload=3a5c",
                         i, bus0.NEXT_CMD, bus0.cmd_valid, {bus0.cmd_op, bus0.cmd_arg});
            end
        end
        bus0.cmd_ready = 1'b1;
        @(negedge clk);
        bus0.cmd_ready = 1'b0;
        checks++;
        if ({bus0.NEXT_CMD, bus0.cmd_valid} !== 2'b10) begin
            fails++;
            $display("FAIL accept_next_cmd: got nc=%b v=%b, want nc=1 v=0", bus0.NEXT_CMD, bus0.cmd_valid);
        end
    endtask

    task automatic test_streaming();
        int          acc_cyc [0:7];
        logic [15:0] acc_word [0:7];
        int          n_acc = 0;
        int          cyc = 0;
        bit          done = 0;
        apply_reset();
        mem[mptr]         = 16'h1001;
        mem[mptr + 9'd1]  = 16'h2002;
        mem[mptr + 9'd2]  = 16'h3003;
        mem[mptr + 9'd3]  = 16'hF000;
        bus0.cmd_ready = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        while (!done && cyc < 60) begin
            if (bus0.cmd_valid && n_acc < 8) begin
                acc_cyc[n_acc]  = cyc;
                acc_word[n_acc] = {bus0.cmd_op, bus0.cmd_arg};
                n_acc++;
            end
            if (halted0) done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus0.cmd_ready = 1'b0;
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL stream_halt_timeout: halted not reached within %0d cycles", cyc);
        end
        checks++;
        if (n_acc !== 3) begin
            fails++;
            $display("FAIL stream_accept_count: got %0d, want 3", n_acc);
        end else begin
            checks++;
            if ({acc_word[0], acc_word[1], acc_word[2]} !== {16'h1001, 16'h2002, 16'h3003}) begin
                fails++;
                $display("FAIL stream_words: got %h %h %h, want 1001 2002 3003", acc_word[0], acc_word[1], acc_word[2]);
            end
            checks++;
            if ((acc_cyc[1] - acc_cyc[0] !== 4) || (acc_cyc[2] - acc_cyc[1] !== 4)) begin
                fails++;
                $display("FAIL stream_spacing: got %0d and %0d cycles, want 4 and 4",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
        checks++;
        if ({halted0, busy0, bus0.cmd_valid, bus0.cmd_op, bus0.cmd_arg, fc0} !== {3'b100, 16'hF000, 8'd4}) begin
            fails++;
            $display("FAIL stream_halt_state: got halt=%b busy=%b v=%b op=%h arg=%h fc=%0d, want 1 0 0 f 000 4",
                     halted0, busy0, bus0.cmd_valid, bus0.cmd_op, bus0.cmd_arg, fc0);
        end
    endtask

    task automatic test_restart();
        int cyc = 0;
        mem[mptr] = 16'h4004;
        bus0.cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if ({halted0, bus0.NEXT_CMD} !== 2'b01) begin
            fails++;
            $display("FAIL restart_edge: got halt=%b nc=%b, want halt=0 nc=1", halted0, bus0.NEXT_CMD);
        end
        while (!bus0.cmd_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!bus0.cmd_valid) begin
            fails++;
            $display("FAIL restart_valid_timeout: cmd_valid not seen within 10 cycles");
        end
        checks++;
        if ({bus0.cmd_op, bus0.cmd_arg, fc0} !== {16'h4004, 8'd5}) begin
            fails++;
            $display("FAIL restart_payload: got op=%h arg=%h fc=%0d, want 4 004 5", bus0.cmd_op, bus0.cmd_arg, fc0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int cyc = 0;
        mem[mptr] = 16'h7777;
        bus0.cmd_ready = 1'b1;
        @(negedge clk);
        bus0.cmd_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy0, bus0.NEXT_CMD, bus0.cmd_valid} !== 3'b100) begin
            fails++;
            $display("FAIL wait_state: got busy=%b nc=%b v=%b, want 1 0 0", busy0, bus0.NEXT_CMD, bus0.cmd_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus0.NEXT_CMD, bus0.cmd_valid, bus0.cmd_op, bus0.cmd_arg, busy0, halted0, fc0} !== 28'd0) begin
            fails++;
            $display("FAIL async_reset: got nc=%b v=%b op=%h arg=%h busy=%b halt=%b fc=%0d, want all 0",
                     bus0.NEXT_CMD, bus0.cmd_valid, bus0.cmd_op, bus0.cmd_arg, busy0, halted0, fc0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({bus0.NEXT_CMD, busy0, bus0.cmd_valid} !== 3'b000) begin
                fails++;
                $display("FAIL post_reset_idle_%0d: got nc=%b busy=%b v=%b, want 000", i, bus0.NEXT_CMD, busy0, bus0.cmd_valid);
            end
        end
        mem[mptr] = 16'h0BEE;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (bus0.NEXT_CMD !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_start: got nc=%b, want 1", bus0.NEXT_CMD);
        end
        while (!bus0.cmd_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({bus0.cmd_valid, bus0.cmd_op, bus0.cmd_arg, fc0} !== {1'b1, 16'h0BEE, 8'd1}) begin
            fails++;
            $display("FAIL post_reset_fetch: got v=%b op=%h arg=%h fc=%0d, want 1 0 bee 1",
                     bus0.cmd_valid, bus0.cmd_op, bus0.cmd_arg, fc0);
        end
    endtask

    task automatic test_wrap_lat1();
        int pulses = 0;
        int last = 0;
        int first = -1;
        int bad_gap = 0;
        int cyc = 0;
        bus1.data = 16'h1234;
        bus1.cmd_ready = 1'b1;
        start1 = 1'b1;
        while (pulses < 257 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start1 = cyc[0];
            if (bus1.NEXT_CMD) begin
                if (pulses == 0) first = cyc;
                else if (cyc - last != 3) bad_gap++;
                last = cyc;
                pulses++;
            end
        end
        bus1.cmd_ready = 1'b0;
        start1 = 1'b0;
        checks++;
        if (pulses !== 257) begin
            fails++;
            $display("FAIL wrap_pulse_timeout: got %0d pulses in %0d cycles, want 257", pulses, cyc);
        end
        checks++;
        if (first !== 1) begin
            fails++;
            $display("FAIL lat1_first_request: got cycle %0d, want 1", first);
        end
        checks++;
        if (bad_gap !== 0) begin
            fails++;
            $display("FAIL lat1_period: got %0d gaps not equal to 3 cycles, want 0", bad_gap);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({fc1, bus1.cmd_valid, bus1.NEXT_CMD, busy1, bus1.cmd_op, bus1.cmd_arg} !== {8'd1, 3'b101, 16'h1234}) begin
            fails++;
            $display("FAIL wrap_final: got fc=%0d v=%b nc=%b busy=%b payload=%h, want fc=1 v=1 nc=0 busy=1 payload=1234",
                     fc1, bus1.cmd_valid, bus1.NEXT_CMD, busy1, {bus1.cmd_op, bus1.cmd_arg});
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol0 !== 0) begin
            fails++;
            $display("FAIL protocol_dut0: got %0d violations, want 0", viol0);
        end
        checks++;
        if (viol1 !== 0) begin
            fails++;
            $display("FAIL protocol_dut1: got %0d violations, want 0", viol1);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_streaming();
        test_restart();
        test_reset_mid_wait();
        test_wrap_lat1();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
